frame_pad_scheduler: RTL and testbench

// Line-level sequencer for vertical frame padding. Issues one command per output line to the

---
 rtl/frame_pad_scheduler.sv | 154 +++++++++++++++
 tb/tb_frame_pad_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pad_scheduler.sv
// Vertical frame padding sequencer: emits one STORE/PASS/REPLAY command per line so each
// frame leaves as TOP copies of line 0, the body lines, then BOTTOM copies of the last line.
module frame_pad_scheduler #(
  parameter int TOP         = 1,
  parameter int BOTTOM      = 1,
  parameter int FRAME_RES_Y = 1080,
  parameter int CNT_WIDTH   = $clog2(TOP + FRAME_RES_Y + BOTTOM + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 in_sof_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [1:0]           cmd_op_o,
  output logic                 cmd_sof_o,
  output logic                 cmd_eof_o,
  input  logic                 done_i,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic [CNT_WIDTH-1:0] out_line_o,
  output logic [1:0]           state_o
);

  // Handshake: a command is transferred on a cycle where cmd_valid_o && cmd_ready_i; the
  // payload is held stable from the first valid cycle until that transfer.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0] OP_STORE  = 2'd0;
  localparam logic [1:0] OP_PASS   = 2'd1;
  localparam logic [1:0] OP_REPLAY = 2'd2;

  // Command index 0 is the STORE; index k >= 1 produces output line k-1.
  localparam logic [CNT_WIDTH-1:0] LAST_PAD_C = CNT_WIDTH'(TOP + 1);
  localparam logic [CNT_WIDTH-1:0] BODY_END_C = CNT_WIDTH'(TOP + FRAME_RES_Y);
  localparam logic [CNT_WIDTH-1:0] TOTAL_C    = CNT_WIDTH'(TOP + FRAME_RES_Y + BOTTOM);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] line_q, line_d;
  logic [1:0]           op_q, op_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic                 short_q, short_d;
  logic                 err_q, err_d;

  logic                 load;
  logic                 first;
  logic [CNT_WIDTH-1:0] nxt_idx;
  logic                 pass_cand;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      line_q  <= '0;
      op_q    <= OP_STORE;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      short_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      op_q    <= op_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      short_q <= short_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    first   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i && in_sof_i) begin
          state_d = ST_ISSUE;
          load    = 1'b1;
          first   = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_i) begin
          if (!eof_q) begin
            state_d = ST_ISSUE;
            load    = 1'b1;
          end else if (en_i && in_sof_i) begin
            state_d = ST_ISSUE;
            load    = 1'b1;
            first   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    nxt_idx   = first ? '0 : idx_q + CNT_WIDTH'(1);
    pass_cand = (nxt_idx > LAST_PAD_C) && (nxt_idx <= BODY_END_C);

    idx_d   = idx_q;
    line_d  = line_q;
    op_d    = op_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    short_d = short_q;
    err_d   = 1'b0;
    if (load) begin
      idx_d  = nxt_idx;
      line_d = (nxt_idx == '0) ? '0 : nxt_idx - CNT_WIDTH'(1);
      sof_d  = (nxt_idx == CNT_WIDTH'(1));
      eof_d  = (nxt_idx == TOTAL_C);
      // A new frame head arriving where a body line was due means the input frame was short;
      // the remaining body lines are padded from the buffer instead.
      if (nxt_idx == '0) begin
        op_d    = OP_STORE;
        short_d = 1'b0;
      end else if (pass_cand && !short_q && !in_sof_i) begin
        op_d = OP_PASS;
      end else begin
        op_d = OP_REPLAY;
        if (pass_cand && !short_q) begin
          short_d = 1'b1;
          err_d   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cmd_valid_o = (state_q == ST_ISSUE);
    busy_o      = (state_q != ST_IDLE);
    cmd_op_o    = op_q;
    cmd_sof_o   = sof_q;
    cmd_eof_o   = eof_q;
    frame_err_o = err_q;
    out_line_o  = line_q;
    state_o     = state_q;
  end

endmodule

// File: tb/tb_frame_pad_scheduler.sv
// Bench for frame_pad_scheduler: a 1/1/3 padding instance driven with randomized handshakes and
// short frames against a phase-list model, plus a 0/0/1 instance driven directly.
module tb_frame_pad_scheduler;

  localparam int A_TOP = 1;
  localparam int A_BOT = 1;
  localparam int A_RES = 3;
  localparam int A_CW  = $clog2(A_TOP + A_RES + A_BOT + 1);
  localparam int B_CW  = $clog2(0 + 1 + 0 + 1);

  localparam logic [1:0] OP_S = 2'd0;
  localparam logic [1:0] OP_P = 2'd1;
  localparam logic [1:0] OP_R = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_rst, a_en, a_sof_in, a_ready, a_done;
  logic            a_valid, a_sof, a_eof, a_busy, a_err;
  logic [1:0]      a_op, a_state;
  logic [A_CW-1:0] a_line;

  logic            b_rst, b_en, b_sof_in, b_ready, b_done;
  logic            b_valid, b_sof, b_eof, b_busy, b_err;
  logic [1:0]      b_op, b_state;
  logic [B_CW-1:0] b_line;

  frame_pad_scheduler #(.TOP(A_TOP), .BOTTOM(A_BOT), .FRAME_RES_Y(A_RES)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .en_i(a_en), .in_sof_i(a_sof_in),
    .cmd_valid_o(a_valid), .cmd_ready_i(a_ready), .cmd_op_o(a_op),
    .cmd_sof_o(a_sof), .cmd_eof_o(a_eof), .done_i(a_done), .busy_o(a_busy),
    .frame_err_o(a_err), .out_line_o(a_line), .state_o(a_state)
  );

  frame_pad_scheduler #(.TOP(0), .BOTTOM(0), .FRAME_RES_Y(1)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .en_i(b_en), .in_sof_i(b_sof_in),
    .cmd_valid_o(b_valid), .cmd_ready_i(b_ready), .cmd_op_o(b_op),
    .cmd_sof_o(b_sof), .cmd_eof_o(b_eof), .done_i(b_done), .busy_o(b_busy),
    .frame_err_o(b_err), .out_line_o(b_line), .state_o(b_state)
  );

  wire [15:0] a_pay = {a_op, a_sof, a_eof, 12'(a_line)};
  wire [15:0] b_pay = {b_op, b_sof, b_eof, 12'(b_line)};

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic [1:0] op, input int line, input int total, input bit outp);
    logic s, e;
    s = outp && (line == 0);
    e = outp && (line == total - 1);
    return {op, s, e, 12'(line)};
  endfunction

  // Model: phase list STORE, REPLAY x(TOP+1), PASS x(RES-1), REPLAY x BOTTOM; a short frame
  // starting at body pass index short_k turns that PASS and all later ones into REPLAY.
  task automatic a_build(input int short_k);
    int total;
    int line;
    total = A_TOP + A_RES + A_BOT;
    line  = 0;
    exp_q.delete();
    exp_q.push_back(pk(OP_S, 0, total, 1'b0));
    for (int i = 0; i < A_TOP + 1; i++) begin
      exp_q.push_back(pk(OP_R, line, total, 1'b1)); line++;
    end
    for (int i = 0; i < A_RES - 1; i++) begin
      exp_q.push_back(pk((short_k >= 0 && i >= short_k) ? OP_R : OP_P, line, total, 1'b1)); line++;
    end
    for (int i = 0; i < A_BOT; i++) begin
      exp_q.push_back(pk(OP_R, line, total, 1'b1)); line++;
    end
  endtask

  // driver tasks
  task automatic a_wait_valid(output int waited, output bit ok);
    waited = 0;
    ok     = 1'b1;
    while (!a_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!a_valid) begin
      check("a_valid_timeout", 32'(a_valid), 32'd1);
      ok = 1'b0;
    end
  endtask

  task automatic a_start();
    a_en     = 1'b1;
    a_sof_in = 1'b1;
    @(negedge clk);
    a_sof_in = 1'b0;
  endtask

  task automatic a_frame(input int short_k, input int stall_fix, input int dly_fix,
                         input bit next_sof, input bit next_en);
    int  scmd, waited, stall, dly;
    bit  ok;
    scmd = (short_k >= 0) ? 1 + A_TOP + 1 + short_k : -1;
    a_build(short_k);
    for (int j = 0; j < exp_q.size(); j++) begin
      a_wait_valid(waited, ok);
      if (!ok) return;
      check("a_issue_latency", 32'(waited), 32'd0);
      check("a_payload", 32'(a_pay), 32'(exp_q[j]));
      check("a_frame_err", 32'(a_err), 32'(j == scmd));
      check("a_busy", 32'(a_busy), 32'd1);
      stall = (stall_fix >= 0) ? stall_fix : $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        a_ready  = 1'b0;
        a_done   = 1'($urandom_range(0, 1));
        a_en     = 1'($urandom_range(0, 1));
        a_sof_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("a_valid_held", 32'(a_valid), 32'd1);
        check("a_payload_held", 32'(a_pay), 32'(exp_q[j]));
        check("a_err_once", 32'(a_err), 32'd0);
      end
      a_ready = 1'b1;
      a_done  = 1'($urandom_range(0, 1));
      @(negedge clk);
      a_ready  = 1'b0;
      a_done   = 1'b0;
      a_sof_in = 1'b0;
      check("a_valid_drop", 32'(a_valid), 32'd0);
      check("a_busy_wait", 32'(a_busy), 32'd1);
      dly = (dly_fix >= 0) ? dly_fix : $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        a_en     = 1'($urandom_range(0, 1));
        a_sof_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("a_wait_no_valid", 32'(a_valid), 32'd0);
        check("a_wait_no_err", 32'(a_err), 32'd0);
      end
      a_done = 1'b1;
      if (j == exp_q.size() - 1) begin
        a_sof_in = next_sof;
        a_en     = next_en;
      end else begin
        a_sof_in = (j + 1 == scmd);
        a_en     = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      a_done   = 1'b0;
      a_sof_in = 1'b0;
    end
    if (!(next_sof && next_en)) begin
      check("a_idle_after_eof", 32'(a_busy), 32'd0);
      check("a_no_valid_idle", 32'(a_valid), 32'd0);
    end
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_valid"}, 32'(a_valid), 32'd0);
    check({tag, "_busy"}, 32'(a_busy), 32'd0);
    check({tag, "_payload"}, 32'(a_pay), 32'd0);
    check({tag, "_err"}, 32'(a_err), 32'd0);
    check({tag, "_state"}, 32'(a_state), 32'd0);
  endtask

  initial begin
    int  waited, sk;
    bit  ok, b2b, in_frame;
    a_rst = 1'b0; a_en = 1'b0; a_sof_in = 1'b0; a_ready = 1'b0; a_done = 1'b0;
    b_rst = 1'b0; b_en = 1'b0; b_sof_in = 1'b0; b_ready = 1'b0; b_done = 1'b0;
    repeat (3) @(negedge clk);
    check_a_zero("rst_a");
    check("rst_b_payload", 32'(b_pay), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    a_rst = 1'b1;
    b_rst = 1'b1;

    // frame head without enable, and enable without frame head: stay idle
    a_sof_in = 1'b1; a_en = 1'b0;
    @(negedge clk);
    check("a_idle_no_en", 32'(a_busy), 32'd0);
    a_sof_in = 1'b0; a_en = 1'b1;
    @(negedge clk);
    check("a_idle_no_sof", 32'(a_busy), 32'd0);

    // nominal frame, done two cycles after accept
    a_start();
    a_frame(-1, 0, 2, 1'b0, 1'b1);
    // long ready stall
    a_start();
    a_frame(-1, 5, -1, 1'b0, 1'b1);
    // short frame at second PASS, then back-to-back frames
    a_start();
    a_frame(1, -1, -1, 1'b1, 1'b1);
    a_frame(-1, -1, -1, 1'b1, 1'b1);
    a_frame(0, -1, -1, 1'b0, 1'b1);

    // randomized frames
    in_frame = 1'b0;
    for (int f = 0; f < 8; f++) begin
      sk  = int'($urandom_range(0, 2)) - 1;
      b2b = 1'($urandom_range(0, 1));
      if (!in_frame) a_start();
      a_frame(sk, -1, -1, b2b, 1'b1);
      in_frame = b2b;
    end
    if (in_frame) a_frame(-1, -1, -1, 1'b0, 1'b0);

    // reset while waiting for done; a late done must not restart anything
    a_start();
    a_wait_valid(waited, ok);
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    check("a_pre_rst_wait", 32'(a_busy), 32'd1);
    a_rst = 1'b0;
    @(negedge clk);
    check_a_zero("rst_wait");
    a_rst  = 1'b1;
    a_en   = 1'b0;
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
    repeat (3) @(negedge clk);
    check("a_done_ignored_busy", 32'(a_busy), 32'd0);
    check("a_done_ignored_valid", 32'(a_valid), 32'd0);
    a_start();
    a_frame(-1, -1, -1, 1'b0, 1'b0);

    // TOP=0, BOTTOM=0, RES_Y=1: STORE then one REPLAY with sof=eof=1
    b_en = 1'b1; b_sof_in = 1'b1;
    @(negedge clk);
    b_sof_in = 1'b0;
    check("b_store_valid", 32'(b_valid), 32'd1);
    check("b_store_payload", 32'(b_pay), 32'({OP_S, 1'b0, 1'b0, 12'd0}));
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check("b_store_drop", 32'(b_valid), 32'd0);
    repeat (2) @(negedge clk);
    b_done = 1'b1;
    @(negedge clk);
    b_done = 1'b0;
    check("b_replay_valid", 32'(b_valid), 32'd1);
    check("b_replay_payload", 32'(b_pay), 32'({OP_R, 1'b1, 1'b1, 12'd0}));
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    b_en    = 1'b0;
    b_done  = 1'b1;
    @(negedge clk);
    b_done = 1'b0;
    check("b_idle", 32'(b_busy), 32'd0);
    check("b_no_err", 32'(b_err), 32'd0);
    check("b_last_line", 32'(b_line), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
